// File: rtl/sent_tx_frame_gen.sv
// SENT (SAE J2716) fast-channel frame transmitter: sync, status, data nibbles, CRC-4
// and an optional fixed or constant-frame pause, fed through a valid/ready handshake.
module sent_tx_frame_gen #(
    parameter int NIBBLES     = 6,
    parameter int DIV_W       = 8,
    parameter int LOW_TICKS   = 5,
    parameter int FRAME_TICKS = 282,
    parameter int REPEAT_LAST = 1
) (
    input  logic                 clk_tx,
    input  logic                 reset_tx,
    input  logic                 enable_i,
    input  logic [DIV_W-1:0]     divide_i,
    input  logic [1:0]           pause_mode_i,
    input  logic [11:0]          pause_ticks_i,
    input  logic [3:0]           status_i,
    input  logic [4*NIBBLES-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    output logic                 sent_tx_o,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 underrun_o,
    output logic                 pause_clip_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SYNC   = 3'd1;
    localparam logic [2:0] ST_STATUS = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CRC    = 3'd4;
    localparam logic [2:0] ST_PAUSE  = 3'd5;

    localparam logic [11:0] SYNC_TICKS = 12'd56;
    localparam logic [11:0] NIB_BASE   = 12'd12;
    localparam logic [11:0] MIN_PAUSE  = 12'd12;
    localparam logic [11:0] FRAME_LEN  = 12'(FRAME_TICKS);
    localparam logic [11:0] LOW_LEN    = 12'(LOW_TICKS);
    localparam logic [2:0]  LAST_NIB   = 3'(NIBBLES - 1);
    localparam logic [2:0]  CRC_STEPS  = 3'(NIBBLES);
    localparam logic [3:0]  CRC_SEED   = 4'd5;
    localparam bit          REPEAT_EN  = (REPEAT_LAST != 0);

    function automatic logic [3:0] crc_table(input logic [3:0] c);
        logic [3:0] t;
        case (c)
            4'd0:    t = 4'd0;
            4'd1:    t = 4'd13;
            4'd2:    t = 4'd7;
            4'd3:    t = 4'd10;
            4'd4:    t = 4'd14;
            4'd5:    t = 4'd3;
            4'd6:    t = 4'd9;
            4'd7:    t = 4'd4;
            4'd8:    t = 4'd1;
            4'd9:    t = 4'd12;
            4'd10:   t = 4'd6;
            4'd11:   t = 4'd11;
            4'd12:   t = 4'd15;
            4'd13:   t = 4'd2;
            4'd14:   t = 4'd8;
            default: t = 4'd5;
        endcase
        return t;
    endfunction

    // Nibble k in send order; k=0 is the most significant nibble of the word.
    function automatic logic [3:0] get_nib(input logic [4*NIBBLES-1:0] d, input logic [2:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (k == 3'(i)) n = d[4*(NIBBLES-1-i) +: 4];
        end
        return n;
    endfunction

    logic [2:0]           state_q, state_d;
    logic [11:0]          tick_cnt_q, tick_cnt_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [2:0]           nib_idx_q, nib_idx_d;
    logic [4*NIBBLES-1:0] data_q;
    logic [3:0]           status_q;
    logic [DIV_W-1:0]     div_q;
    logic [1:0]           mode_q;
    logic [11:0]          pticks_q;
    logic [3:0]           crc_q;
    logic [2:0]           crc_step_q;
    logic                 crc_run_q;
    logic                 sent_tx_q, sent_tx_d;
    logic                 underrun_q;
    logic                 pause_clip_q, pause_clip_d;

    logic [DIV_W-1:0] div_eff;
    logic [11:0]      data_sum, frame_used, pause_len, pulse_len;
    logic             pause_short, has_pause;
    logic             tick, last_tick, frame_end, transfer, repeat_frame, start;

    // Pause length from the latched frame; the CRC has settled long before PAUSE.
    always_comb begin
        data_sum = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            data_sum = data_sum + NIB_BASE + 12'(data_q[4*i +: 4]);
        end
        frame_used  = SYNC_TICKS + NIB_BASE + 12'(status_q) + data_sum + NIB_BASE + 12'(crc_q);
        pause_len   = MIN_PAUSE;
        pause_short = 1'b0;
        if (mode_q == 2'd1) begin
            if (pticks_q < MIN_PAUSE) pause_short = 1'b1;
            else                      pause_len   = pticks_q;
        end else if (mode_q == 2'd2) begin
            if (FRAME_LEN < frame_used + MIN_PAUSE) pause_short = 1'b1;
            else                                    pause_len   = FRAME_LEN - frame_used;
        end
    end

    always_comb begin
        case (state_q)
            ST_STATUS: pulse_len = NIB_BASE + 12'(status_q);
            ST_DATA:   pulse_len = NIB_BASE + 12'(get_nib(data_q, nib_idx_q));
            ST_CRC:    pulse_len = NIB_BASE + 12'(crc_q);
            ST_PAUSE:  pulse_len = pause_len;
            default:   pulse_len = SYNC_TICKS;
        endcase
    end

    assign has_pause    = (mode_q == 2'd1) || (mode_q == 2'd2);
    assign div_eff      = (div_q == '0) ? DIV_W'(1) : div_q;
    assign tick         = (state_q != ST_IDLE) && (div_cnt_q == div_eff - DIV_W'(1));
    assign last_tick    = tick && (tick_cnt_q == pulse_len - 12'd1);
    assign frame_end    = last_tick && ((state_q == ST_PAUSE) || ((state_q == ST_CRC) && !has_pause));
    assign data_ready_o = enable_i && !reset_tx && ((state_q == ST_IDLE) || frame_end);
    assign transfer     = data_valid_i && data_ready_o;
    assign repeat_frame = REPEAT_EN && frame_end && !transfer && enable_i && !reset_tx;
    assign start        = transfer || repeat_frame;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        nib_idx_d  = nib_idx_q;
        div_cnt_d  = div_cnt_q;
        if (state_q == ST_IDLE) begin
            div_cnt_d  = '0;
            tick_cnt_d = '0;
            nib_idx_d  = '0;
            if (transfer) state_d = ST_SYNC;
        end else if (!tick) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end else begin
            div_cnt_d = '0;
            if (!last_tick) begin
                tick_cnt_d = tick_cnt_q + 12'd1;
            end else begin
                tick_cnt_d = '0;
                case (state_q)
                    ST_SYNC:   state_d = ST_STATUS;
                    ST_STATUS: begin
                        state_d   = ST_DATA;
                        nib_idx_d = '0;
                    end
                    ST_DATA: begin
                        if (nib_idx_q == LAST_NIB) state_d   = ST_CRC;
                        else                       nib_idx_d = nib_idx_q + 3'd1;
                    end
                    ST_CRC:   state_d = has_pause ? ST_PAUSE : (start ? ST_SYNC : ST_IDLE);
                    ST_PAUSE: state_d = start ? ST_SYNC : ST_IDLE;
                    default:  state_d = ST_IDLE;
                endcase
            end
        end
        sent_tx_d    = !((state_d != ST_IDLE) && (tick_cnt_d < LOW_LEN));
        pause_clip_d = last_tick && (state_q == ST_CRC) && has_pause && pause_short;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_tx) begin
        if (reset_tx) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            div_cnt_q    <= '0;
            nib_idx_q    <= '0;
            data_q       <= '0;
            status_q     <= '0;
            div_q        <= '0;
            mode_q       <= '0;
            pticks_q     <= '0;
            crc_q        <= '0;
            crc_step_q   <= '0;
            crc_run_q    <= 1'b0;
            sent_tx_q    <= 1'b1;
            underrun_q   <= 1'b0;
            pause_clip_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            div_cnt_q    <= div_cnt_d;
            nib_idx_q    <= nib_idx_d;
            sent_tx_q    <= sent_tx_d;
            underrun_q   <= repeat_frame;
            pause_clip_q <= pause_clip_d;
            // Timing config is re-sampled for every frame, including repeats.
            if (start) begin
                div_q    <= divide_i;
                mode_q   <= pause_mode_i;
                pticks_q <= pause_ticks_i;
            end
            if (transfer) begin
                data_q     <= data_i;
                status_q   <= status_i;
                crc_q      <= CRC_SEED;
                crc_step_q <= '0;
                crc_run_q  <= 1'b1;
            end else if (crc_run_q) begin
                if (crc_step_q == CRC_STEPS) begin
                    crc_q     <= crc_table(crc_q);
                    crc_run_q <= 1'b0;
                end else begin
                    crc_q      <= get_nib(data_q, crc_step_q) ^ crc_table(crc_q);
                    crc_step_q <= crc_step_q + 3'd1;
                end
            end
        end
    end

    assign sent_tx_o    = sent_tx_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = frame_end && !reset_tx;
    assign underrun_o   = underrun_q;
    assign pause_clip_o = pause_clip_q;

endmodule

// File: tb/tb_sent_tx_frame_gen.sv
// Directed bench for sent_tx_frame_gen: decodes pulse widths on the SENT line and
// compares them with hand-computed frames (CRC, pause, clip, repeat, reset corners).
module tb_sent_tx_frame_gen;

    localparam int NIB = 6;
    localparam int LOW = 5;

    logic        clk_tx   = 1'b0;
    logic        reset_tx = 1'b1;
    logic        en_a = 1'b0, en_b = 1'b0, valid_a = 1'b0, valid_b = 1'b0;
    logic [7:0]  divide = 8'd1;
    logic [1:0]  pmode  = 2'd0;
    logic [11:0] pticks = 12'd0;
    logic [3:0]  status = 4'd0;
    logic [23:0] data   = 24'd0;

    logic ready_a, sent_a, busy_a, done_a, und_a, clip_a;
    logic ready_b, sent_b, busy_b, done_b, und_b, clip_b;

    always #5 clk_tx = ~clk_tx;

    sent_tx_frame_gen dut_a (
        .clk_tx(clk_tx), .reset_tx(reset_tx), .enable_i(en_a), .divide_i(divide),
        .pause_mode_i(pmode), .pause_ticks_i(pticks), .status_i(status), .data_i(data),
        .data_valid_i(valid_a), .data_ready_o(ready_a), .sent_tx_o(sent_a), .busy_o(busy_a),
        .frame_done_o(done_a), .underrun_o(und_a), .pause_clip_o(clip_a)
    );

    sent_tx_frame_gen #(.FRAME_TICKS(200), .REPEAT_LAST(0)) dut_b (
        .clk_tx(clk_tx), .reset_tx(reset_tx), .enable_i(en_b), .divide_i(divide),
        .pause_mode_i(pmode), .pause_ticks_i(pticks), .status_i(status), .data_i(data),
        .data_valid_i(valid_b), .data_ready_o(ready_b), .sent_tx_o(sent_b), .busy_o(busy_b),
        .frame_done_o(done_b), .underrun_o(und_b), .pause_clip_o(clip_b)
    );

    bit   use_b = 1'b0;
    logic ready_m, sent_m, busy_m, done_m, und_m, clip_m;
    assign ready_m = use_b ? ready_b : ready_a;
    assign sent_m  = use_b ? sent_b  : sent_a;
    assign busy_m  = use_b ? busy_b  : busy_a;
    assign done_m  = use_b ? done_b  : done_a;
    assign und_m   = use_b ? und_b   : und_a;
    assign clip_m  = use_b ? clip_b  : clip_a;

    typedef struct {
        bit          use_b;
        logic [23:0] data;
        logic [3:0]  status;
        logic [7:0]  div;
        logic [1:0]  mode;
        logic [11:0] pticks;
        int          exp_crc;
        int          exp_pause;
        int          exp_clip;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    int plen[$];
    int sync_low, und_cnt, clip_cnt, first_fall, rdy_at_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_en(input logic v);
        if (use_b) en_b = v; else en_a = v;
    endtask

    task automatic set_valid(input logic v);
        if (use_b) valid_b = v; else valid_a = v;
    endtask

    task automatic send(input vec_t v, input bit keep_valid);
        @(negedge clk_tx);
        use_b  = v.use_b;
        data   = v.data;
        status = v.status;
        divide = v.div;
        pmode  = v.mode;
        pticks = v.pticks;
        set_en(1'b1);
        set_valid(1'b1);
        #1;
        for (int i = 0; i < 100 && !ready_m; i++) begin
            @(negedge clk_tx);
            #1;
        end
        check("ready_before_transfer", ready_m, 1);
        @(posedge clk_tx);
        #1;
        if (!keep_valid) set_valid(1'b0);
    endtask

    // Records falling-edge to falling-edge widths (cycles) until frame_done_o.
    task automatic capture(input int drop_at);
        int   last_fall;
        logic prev;
        bit   done;
        plen.delete();
        sync_low = 0; und_cnt = 0; clip_cnt = 0; first_fall = -1; rdy_at_done = -1;
        last_fall = -1; prev = 1'b1; done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk_tx);
            if (prev && !sent_m) begin
                if (last_fall >= 0) plen.push_back(c - last_fall);
                else                first_fall = c;
                last_fall = c;
            end
            if (plen.size() == 0 && last_fall >= 0 && !sent_m) sync_low++;
            prev = sent_m;
            if (und_m)  und_cnt++;
            if (clip_m) clip_cnt++;
            if (done_m) begin
                rdy_at_done = int'(ready_m);
                plen.push_back(c + 1 - last_fall);
                done = 1'b1;
            end
            if (c == drop_at) begin
                set_en(1'b0);
                set_valid(1'b0);
            end
        end
        check("frame_done_seen", 32'(done), 1);
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        int dv;
        int e[$];
        int sum_exp, sum_act;
        dv = (v.div == 8'd0) ? 1 : int'(v.div);
        e.push_back(56);
        e.push_back(12 + int'(v.status));
        for (int k = 0; k < NIB; k++) e.push_back(12 + int'(v.data[4*(NIB-1-k) +: 4]));
        e.push_back(12 + v.exp_crc);
        if (v.exp_pause > 0) e.push_back(v.exp_pause);
        check({tag, "_pulse_count"}, plen.size(), e.size());
        sum_exp = 0;
        sum_act = 0;
        for (int i = 0; i < e.size(); i++) sum_exp += e[i] * dv;
        for (int i = 0; i < plen.size(); i++) sum_act += plen[i];
        for (int i = 0; i < e.size() && i < plen.size(); i++)
            check($sformatf("%s_pulse%0d_cycles", tag, i), plen[i], e[i] * dv);
        check({tag, "_frame_cycles"}, sum_act, sum_exp);
        check({tag, "_sync_low_cycles"}, sync_low, LOW * dv);
        check({tag, "_pause_clip_pulses"}, clip_cnt, v.exp_clip);
        check({tag, "_underrun_pulses"}, und_cnt, 0);
    endtask

    task automatic expect_idle(input string tag);
        int und;
        und = 0;
        repeat (3) begin
            @(negedge clk_tx);
            if (und_m) und++;
        end
        check({tag, "_idle_busy"}, busy_m, 0);
        check({tag, "_idle_line"}, sent_m, 1);
        check({tag, "_idle_done"}, done_m, 0);
        check({tag, "_idle_underrun"}, und, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        vec_t v;
        int   sum;

        vecs[0] = '{1'b0, 24'h000000, 4'h0, 8'd4, 2'd0, 12'd0,   5,  0,   0};
        vecs[1] = '{1'b0, 24'h000000, 4'h0, 8'd2, 2'd2, 12'd0,   5,  125, 0};
        vecs[2] = '{1'b0, 24'h123456, 4'h3, 8'd1, 2'd1, 12'd20,  2,  20,  0};
        vecs[3] = '{1'b0, 24'hFEDCBA, 4'h0, 8'd0, 2'd1, 12'd5,   14, 12,  1};
        vecs[4] = '{1'b0, 24'hA5A5A5, 4'hC, 8'd3, 2'd3, 12'd100, 9,  0,   0};
        vecs[5] = '{1'b0, 24'h123456, 4'h3, 8'd1, 2'd2, 12'd0,   2,  104, 0};
        vecs[6] = '{1'b1, 24'hFFFFFF, 4'hF, 8'd1, 2'd2, 12'd0,   10, 12,  1};

        // Reset state
        repeat (3) @(posedge clk_tx);
        @(negedge clk_tx);
        check("rst_sent", sent_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_ready", ready_a, 0);
        check("rst_done", done_a, 0);
        check("rst_underrun", und_a, 0);
        check("rst_clip", clip_a, 0);
        check("rst_sent_b", sent_b, 1);
        reset_tx = 1'b0;
        en_a = 1'b1;
        #1;
        check("idle_ready_enabled", ready_a, 1);
        repeat (40) @(negedge clk_tx);
        check("no_repeat_before_first_data", busy_a, 0);
        en_a = 1'b0;
        #1;
        check("idle_ready_disabled", ready_a, 0);

        // Single frames from the vector table
        for (int i = 0; i < 7; i++) begin
            send(vecs[i], 1'b0);
            capture(0);
            check_frame($sformatf("vec%0d", i), vecs[i]);
            expect_idle($sformatf("vec%0d", i));
        end

        // Underrun with REPEAT_LAST=1: second frame reuses data
        v = '{1'b0, 24'h000000, 4'h0, 8'd1, 2'd0, 12'd0, 5, 0, 0};
        send(v, 1'b0);
        capture(-1);
        check("rep_f1_underrun", und_cnt, 0);
        check("rep_f1_crc", plen.size() == 9 ? plen[8] : -1, 17);
        capture(0);
        check("rep_f2_underrun", und_cnt, 1);
        check("rep_f2_no_gap", first_fall, 0);
        check("rep_f2_count", plen.size(), 9);
        check("rep_f2_crc", plen.size() == 9 ? plen[8] : -1, 17);
        expect_idle("rep");

        // REPEAT_LAST=0: idles high instead of resending
        v.use_b = 1'b1;
        send(v, 1'b0);
        capture(-1);
        check("norep_crc", plen.size() == 9 ? plen[8] : -1, 17);
        expect_idle("norep");
        en_b = 1'b0;
        use_b = 1'b0;

        // Constant-frame back-to-back: SYNC-to-SYNC period of 282 ticks
        v = '{1'b0, 24'h000000, 4'h0, 8'd1, 2'd2, 12'd0, 5, 125, 0};
        send(v, 1'b1);
        capture(-1);
        check("b2b_f1_pause", plen.size() == 10 ? plen[9] : -1, 125);
        check("b2b_f1_ready_at_end", rdy_at_done, 1);
        capture(1);
        sum = 0;
        for (int i = 0; i < plen.size(); i++) sum += plen[i];
        check("b2b_f2_no_gap", first_fall, 0);
        check("b2b_f2_period", sum, 282);
        check("b2b_f2_underrun", und_cnt, 0);
        expect_idle("b2b");

        // enable_i dropped mid-DATA: frame completes, then IDLE
        v = '{1'b0, 24'h000000, 4'h0, 8'd2, 2'd0, 12'd0, 5, 0, 0};
        send(v, 1'b0);
        capture(184);
        check("endrop_count", plen.size(), 9);
        check("endrop_crc", plen.size() == 9 ? plen[8] : -1, 34);
        check("endrop_ready_at_end", rdy_at_done, 0);
        expect_idle("endrop");

        // Reset during the CRC pulse
        v = '{1'b0, 24'h000000, 4'h0, 8'd1, 2'd0, 12'd0, 5, 0, 0};
        send(v, 1'b0);
        repeat (144) @(negedge clk_tx);
        check("pre_reset_busy", busy_a, 1);
        reset_tx = 1'b1;
        @(posedge clk_tx);
        #1;
        check("midrst_sent", sent_a, 1);
        check("midrst_busy", busy_a, 0);
        @(negedge clk_tx);
        reset_tx = 1'b0;
        repeat (20) @(negedge clk_tx);
        check("midrst_no_resend", busy_a, 0);
        en_a = 1'b0;
        send(vecs[2], 1'b0);
        capture(0);
        check_frame("after_rst", vecs[2]);
        expect_idle("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
